seq_transmit: RTL and testbench
===============================

SEQ_TRANSMIT -- requirements
Module: seq_transmit

Interface
REQ-001 Parameter DATA_W, default 8, payload register width in bits (2..32).
REQ-002 Parameter IDLE_LEVEL, default 1'b0, value driven on out whenever no bit is being transmitted.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request to transmit; sampled only in IDLE.
REQ-006 data  input  DATA_W  payload; captured on the accepted start.
REQ-007 len  input  $clog2(DATA_W)  payload bit count minus one (bits sent = len+1); captured with data.
REQ-008 stall  input  1  freezes transmission while high.
REQ-009 out  output  1  serial bit stream.
REQ-010 out_valid  output  1  high in each cycle in which out carries a transmitted bit.
REQ-011 busy  output  1  high from the cycle after an accepted start through the cycle of the last bit.
REQ-012 done  output  1  single-cycle pulse in the cycle after the last bit.

Function
REQ-013 FSM states SHALL be IDLE, PRE (preamble, macro-dependent), SHIFT, DONE; state register encoded as an enumerated type.
REQ-014 In IDLE with start=1, SHALL capture data into a shift register and len into a bit counter; next state PRE if preamble is enabled, else SHIFT.
REQ-015 Payload SHALL be sent MSB-first starting at bit index len, one bit per unstalled cycle; bits above len never appear on out.
REQ-016 First transmitted bit SHALL appear on out, with out_valid=1, in the cycle after start is accepted (latency 1).
REQ-017 In SHIFT, after bit index 0 is sent, next state SHALL be DONE; DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-018 While stall=1 in PRE or SHIFT: state, counters and out SHALL hold, out_valid=0, busy stays 1; the held bit is re-presented with out_valid=1 when stall drops.
REQ-019 stall SHALL have no effect in IDLE or DONE.
REQ-020 In IDLE and DONE, out SHALL equal IDLE_LEVEL and out_valid=0.
REQ-021 start while busy=1 or in DONE SHALL be ignored; no queuing.
REQ-022 Changes on data/len after capture SHALL not affect the transmission in progress.
REQ-023 len=0 SHALL send exactly one bit (data[0]); len=DATA_W-1 SHALL send all DATA_W bits.
REQ-024 Total cycles from accepted start to done pulse with no stall SHALL be P+len+2, where P=3 with preamble, 0 without.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, out=IDLE_LEVEL, out_valid=0, busy=0, done=0, shift register and counter cleared.
REQ-026 reset SHALL take priority over start and stall; reset mid-transmission aborts with no done pulse.
REQ-027 A start asserted in the same cycle as reset SHALL be discarded.

Configuration
REQ-028 Macro SEQ_TRANSMIT_PREAMBLE_EN defined: state PRE SHALL send the fixed sync preamble 1,1,0 (three bits, out_valid=1, stall-able) before the payload.
REQ-029 Macro SEQ_TRANSMIT_PREAMBLE_EN undefined: state PRE and its counter SHALL not be compiled; IDLE goes directly to SHIFT.

Verification
REQ-030 No preamble, data=8'hA5, len=7, start 1 cycle -> out=1,0,1,0,0,1,0,1 over 8 cycles with out_valid=1, done pulse in cycle 9, busy=0 after.
REQ-031 Preamble, data=8'h03, len=1 -> out=1,1,0,1,1 then done; total 6 cycles start-to-done.
REQ-032 data=8'hFF, len=3, stall=1 for 2 cycles after 2nd bit -> 4 valid 1-bits, out_valid=0 during stall, done at cycle 7.
REQ-033 start re-pulsed at bit 3 of a len=7 frame with different data -> ignored; original frame completes unchanged.
REQ-034 reset asserted at bit 4 of a frame -> next cycle out=IDLE_LEVEL, busy=0, no done; fresh start then sends complete frame.
REQ-035 len=0, data=8'h01 -> single bit 1, done in cycle 2.

Source files
------------

// File: rtl/seq_transmit_if.sv
// seq_transmit_if: request/serial-output bundle for seq_transmit.
// The master side drives start/data/len/stall.
// The slave side (seq_transmit) drives out/out_valid/busy/done.
interface seq_transmit_if #(
   parameter int DATA_W = 8
);
   localparam int LEN_W = $clog2(DATA_W);

   logic              start;
   logic [DATA_W-1:0] data;
   logic [LEN_W-1:0]  len;
   logic              stall;
   logic              out;
   logic              out_valid;
   logic              busy;
   logic              done;

   modport master (
      output start, data, len, stall,
      input  out, out_valid, busy, done
   );

   modport slave (
      input  start, data, len, stall,
      output out, out_valid, busy, done
   );
endinterface

// File: rtl/seq_transmit.sv
// seq_transmit: MSB-first serialiser for a variable-length payload.
// It sends len+1 bits of data, one bit per unstalled cycle, then pulses done.
// Optional feature: define SEQ_TRANSMIT_PREAMBLE_EN to prepend the sync
// preamble 1,1,0 before the payload.
module seq_transmit #(
   parameter int   DATA_W     = 8,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input logic           clk,
   input logic           reset,
   seq_transmit_if.slave bus
);

   localparam int LEN_W = $clog2(DATA_W);
   localparam logic [LEN_W-1:0] MAX_IDX = LEN_W'(DATA_W - 1);

`ifdef SEQ_TRANSMIT_PREAMBLE_EN
   typedef enum logic [1:0] {IDLE, PRE, SHIFT, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t            state, state_next;
   logic [DATA_W-1:0] shreg;    // next bit to send is always at the MSB
   logic [LEN_W-1:0]  bit_cnt;  // bits still to send after the current one
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
   logic [1:0]        pre_cnt;  // preamble position 0..2
`endif

   logic out_bit;
   logic out_vld;
   logic busy_w;
   logic done_w;

   // State register; synchronous reset wins over everything, so a start in the reset cycle is dropped.
   always_ff @(posedge clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Datapath: capture on accepted start, advance one bit per unstalled cycle, hold while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg   <= '0;
         bit_cnt <= '0;
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
         pre_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  // Left-align so bit 'len' lands at the MSB; higher bits are shifted out and never sent.
                  shreg   <= bus.data << (MAX_IDX - bus.len);
                  bit_cnt <= bus.len;
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
                  pre_cnt <= '0;
`endif
               end
            end
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
            PRE: begin
               if (!bus.stall) pre_cnt <= pre_cnt + 2'd1;
            end
`endif
            SHIFT: begin
               if (!bus.stall && bit_cnt != '0) begin
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state and output decode.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next = state;
      out_bit    = IDLE_LEVEL;
      out_vld    = 1'b0;
      busy_w     = 1'b0;
      done_w     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
               state_next = PRE;
`else
               state_next = SHIFT;
`endif
            end
         end
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
         PRE: begin
            busy_w  = 1'b1;
            out_bit = (pre_cnt != 2'd2);   // sync pattern 1,1,0
            out_vld = !bus.stall;
            if (!bus.stall && pre_cnt == 2'd2) state_next = SHIFT;
         end
`endif
         SHIFT: begin
            busy_w  = 1'b1;
            out_bit = shreg[DATA_W-1];
            out_vld = !bus.stall;
            if (!bus.stall && bit_cnt == '0) state_next = DONE;
         end
         DONE: begin
            done_w     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.out       = out_bit;
   assign bus.out_valid = out_vld;
   assign bus.busy      = busy_w;
   assign bus.done      = done_w;

endmodule

// File: tb/tb_seq_transmit.sv
// tb_seq_transmit: randomized self-checking bench for seq_transmit.
// Each frame's expected bit stream is a queue (preamble + payload bits) popped once per unstalled cycle.
module tb_seq_transmit;

   localparam int   DATA_W     = 8;
   localparam logic IDLE_LEVEL = 1'b0;
`ifdef SEQ_TRANSMIT_PREAMBLE_EN
   localparam int P = 3;
`else
   localparam int P = 0;
`endif

   typedef logic bitq_t[$];

   logic clk = 1'b0;
   logic reset;
   int   vectors = 0;
   int   errors  = 0;

   seq_transmit_if #(.DATA_W(DATA_W)) bus ();

   seq_transmit #(.DATA_W(DATA_W), .IDLE_LEVEL(IDLE_LEVEL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Expected serial stream: optional preamble, then data[len] down to data[0].
   function automatic bitq_t frame_bits(input logic [7:0] d, input logic [2:0] l);
      bitq_t q;
      q = {};
      if (P == 3) begin
         q.push_back(1'b1);
         q.push_back(1'b1);
         q.push_back(1'b0);
      end
      for (int i = int'(l); i >= 0; i--) q.push_back(d[i]);
      return q;
   endfunction

   // Observed {busy, out_valid, out, done}.
   function automatic logic [3:0] observe();
      return {bus.busy, bus.out_valid, bus.out, bus.done};
   endfunction

   // Runs one frame from an IDLE DUT. stall_map bit c forces stall in cycle c;
   // stall_pct adds random stalls; repulse throws random starts during the frame.
   task automatic run_frame(input string name, input logic [7:0] d, input logic [2:0] l,
                            input logic [63:0] stall_map, input int stall_pct,
                            input bit repulse, output int done_cycle);
      bitq_t      q;
      logic [3:0] exp;
      logic [3:0] got;
      bit         seen_done;
      q          = frame_bits(d, l);
      done_cycle = -1;
      seen_done  = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.data  = d;
      bus.len   = l;
      bus.stall = 1'($urandom_range(0, 1));   // stall must not matter in IDLE
      #1;
      got = observe();
      exp = {1'b0, 1'b0, IDLE_LEVEL, 1'b0};
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s idle-before-start: got %b want %b", name, got, exp);
      end
      for (int c = 1; c < 200 && !seen_done; c++) begin
         @(negedge clk);
         bus.start = repulse ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.data  = 8'($urandom);
         bus.len   = 3'($urandom);
         bus.stall = (c < 64 && stall_map[c]) || ($urandom_range(0, 99) < stall_pct);
         #1;
         got = observe();
         if (q.size() > 0) begin
            exp = {1'b1, !bus.stall, q[0], 1'b0};
            if (!bus.stall) void'(q.pop_front());
         end else begin
            exp        = {1'b0, 1'b0, IDLE_LEVEL, 1'b1};
            done_cycle = c;
            seen_done  = 1'b1;
         end
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b want %b (busy,vld,out,done)", name, c, got, exp);
         end
      end
      if (!seen_done) begin
         errors++;
         $display("FAIL %s timeout: no done within 200 cycles", name);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.stall = 1'b0;
      #1;
      got = observe();
      exp = {1'b0, 1'b0, IDLE_LEVEL, 1'b0};
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s idle-after-done: got %b want %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      logic [3:0] got;
      // start together with reset must be discarded
      @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.data  = 8'hA5;
      bus.len   = 3'd7;
      @(negedge clk);
      reset     = 1'b0;
      bus.start = 1'b0;
      #1;
      got = observe();
      vectors++;
      if (got !== {1'b0, 1'b0, IDLE_LEVEL, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got %b want %b", got, {1'b0, 1'b0, IDLE_LEVEL, 1'b0});
      end
      @(negedge clk);
      #1;
      got = observe();
      vectors++;
      if (got !== {1'b0, 1'b0, IDLE_LEVEL, 1'b0}) begin
         errors++;
         $display("FAIL reset_start_discarded: got %b want idle", got);
      end
   endtask

   task automatic test_directed();
      int dc;
      run_frame("a5_len7", 8'hA5, 3'd7, 64'd0, 0, 1'b0, dc);
      vectors++;
      if (dc !== P + 7 + 2) begin
         errors++;
         $display("FAIL a5_len7_latency: got %0d want %0d", dc, P + 9);
      end
      run_frame("03_len1", 8'h03, 3'd1, 64'd0, 0, 1'b0, dc);
      vectors++;
      if (dc !== P + 1 + 2) begin
         errors++;
         $display("FAIL 03_len1_latency: got %0d want %0d", dc, P + 3);
      end
      // stall for two cycles right after the 2nd payload bit
      run_frame("ff_len3_stall", 8'hFF, 3'd3, (64'd3 << (P + 3)), 0, 1'b0, dc);
      vectors++;
      if (dc !== P + 7) begin
         errors++;
         $display("FAIL ff_len3_stall_latency: got %0d want %0d", dc, P + 7);
      end
      run_frame("len0", 8'h01, 3'd0, 64'd0, 0, 1'b0, dc);
      vectors++;
      if (dc !== P + 2) begin
         errors++;
         $display("FAIL len0_latency: got %0d want %0d", dc, P + 2);
      end
      run_frame("len0_hi_bits", 8'hFE, 3'd0, 64'd0, 0, 1'b0, dc);
   endtask

   task automatic test_restart_ignored();
      int dc;
      run_frame("restart", 8'h5C, 3'd7, 64'd0, 0, 1'b1, dc);
      vectors++;
      if (dc !== P + 9) begin
         errors++;
         $display("FAIL restart_latency: got %0d want %0d", dc, P + 9);
      end
   endtask

   task automatic test_reset_mid_frame();
      bitq_t      q;
      logic [3:0] got;
      logic [3:0] exp;
      int         dc;
      q = frame_bits(8'hC3, 3'd7);
      @(negedge clk);
      bus.start = 1'b1;
      bus.data  = 8'hC3;
      bus.len   = 3'd7;
      for (int c = 1; c <= P + 4; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         bus.stall = 1'b0;
         #1;
         got = observe();
         exp = {1'b1, 1'b1, q.pop_front(), 1'b0};
         vectors++;
         if (got !== exp) begin
            errors++;
            $display("FAIL midreset_pre cycle %0d: got %b want %b", c, got, exp);
         end
      end
      reset     = 1'b1;
      bus.stall = 1'b1;     // reset outranks stall
      @(negedge clk);
      reset     = 1'b0;
      bus.stall = 1'b0;
      for (int c = 0; c < 12; c++) begin
         #1;
         got = observe();
         vectors++;
         if (got !== {1'b0, 1'b0, IDLE_LEVEL, 1'b0}) begin
            errors++;
            $display("FAIL midreset_abort cycle %0d: got %b want idle", c, got);
         end
         @(negedge clk);
      end
      run_frame("after_reset", 8'hC3, 3'd7, 64'd0, 0, 1'b0, dc);
   endtask

   task automatic test_random();
      int dc;
      for (int n = 0; n < 40; n++) begin
         run_frame("random", 8'($urandom), 3'($urandom), 64'd0, 30, 1'($urandom_range(0, 1)), dc);
      end
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.data  = '0;
      bus.len   = '0;
      bus.stall = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_directed();
      test_restart_ignored();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
